mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- MEM-stage load/store sequencer sitting directly upstream of the data RAM (data_ram256x8 byte array).
- Accepts one byte/halfword/word request from the pipeline and splits it into single-byte RAM beats, big-endian.
- Assembles and extends read data, then returns one response per request; the pipeline stalls on req_ready/rsp_valid.

Parameters:
- ADDR_W, 8, RAM byte-address width (256 bytes).
- RD_LAT, 1, cycles from ram_en (read) to valid ram_dout; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  pipeline request present.
- req_ready  output  1  controller can accept; high only in IDLE.
- req_write  input  1  1=store, 0=load.
- req_size  input  2  00=byte, 01=half, 10=word, 11=reserved.
- req_signed  input  1  loads: 1=sign-extend, 0=zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low N bytes used.
- rsp_valid  output  1  response present; held until rsp_ready.
- rsp_ready  input  1  pipeline takes response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned or reserved-size request.
- ram_en  output  1  one-cycle strobe per byte beat.
- ram_rw  output  1  1=read, 0=write (matches RAM ReadWrite).
- ram_addr  output  ADDR_W  beat byte address.
- ram_din  output  8  write byte.
- ram_dout  input  8  read byte.

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; ram_en=0; ram_rw=1; ram_addr=0; ram_din=0.
- Accept on a rising edge with req_valid & req_ready: latch all req_* fields; set beat counter=0 and N = 1/2/4.
- States: IDLE -> CHECK (combinational on accept) -> ISSUE -> WAIT (reads only) -> RESP -> IDLE.
- Error: size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> skip ISSUE; RESP in the next cycle with rsp_err=1 and rsp_rdata=0; no ram_en.
- ISSUE: ram_en=1 for exactly one cycle; ram_addr = (req_addr + beat) mod 2^ADDR_W (wraps); ram_rw = ~req_write.
- Write beat: ram_din = byte (N-1-beat) of wdata, so the MSB goes first to the lowest address.
- Read beat: WAIT lasts RD_LAT cycles; capture ram_dout on the final WAIT edge into byte (N-1-beat) of the assembly register.
- After the last beat, go to RESP; otherwise increment beat and return to ISSUE.
- RESP: rsp_valid=1; loads extend the N-byte value per req_signed; rsp_valid, rsp_rdata and rsp_err hold until rsp_ready, then return to IDLE (req_ready=1 in the following cycle).
- Latency, accept edge = cycle 0, rsp_ready tied high:
  - word store: beats in cycles 1-4, rsp_valid in cycle 5.
  - word load at RD_LAT=1: rsp_valid in cycle 9.
  - byte load: rsp_valid in cycle 3.
  - error: rsp_valid in cycle 1.
- req_* inputs are ignored outside IDLE; no back-to-back accept in the same cycle as rsp_valid.
- Reset mid-operation: immediate IDLE, ram_en deasserts asynchronously, remaining beats are dropped, and no response is produced.
- ram_en is high in ISSUE only; never in WAIT, RESP or IDLE.

Optional Feature:
- MEM_ACCESS_MISALIGN_EN defined: misaligned half/word requests are legal. They are sequenced byte-by-byte from req_addr, wrap is allowed, and rsp_err is set only for size 11.
- Not defined: misaligned half/word requests give an error response as above.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - state encoding S_IDLE/S_ISSUE/S_WAIT/S_RESP;
  - RW_READ=1/RW_WRITE=0;
  - function size_to_bytes.
- One sub-module, mem_load_extend: combinational N-byte sign/zero extension of the assembly register.

Test Plan:
- Word store addr 0x10, wdata 0xDEADBEEF -> ram writes 0x10=DE, 0x11=AD, 0x12=BE, 0x13=EF in cycles 1-4; rsp_valid in cycle 5 with rsp_err=0.
- Word load addr 0x10 after that store, RD_LAT=1 -> rsp_rdata=0xDEADBEEF in cycle 9.
- Signed byte load of 0x80 at addr 0x05 -> 0xFFFFFF80; unsigned -> 0x00000080; signed half of 0x8001 -> 0xFFFF8001.
- Word load addr 0x11 (macro off) -> rsp_err=1, rsp_rdata=0, no ram_en. Macro on, half load addr 0xFF -> beats at 0xFF then 0x00.
- Hold rsp_ready=0 for 3 cycles after a byte load -> rsp_valid and data stable for those cycles; req_ready=0 throughout.
- Assert rst_n=0 during beat 2 of a word store -> ram_en drops immediately, bytes 3-4 are not written, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the MEM-stage load/store sequencer.
//   size_e   : request size field (byte/half/word/reserved)
//   state_e  : sequencer state encoding
//   RW_READ/RW_WRITE : polarity of the RAM ReadWrite strobe
//   size_to_bytes    : number of byte beats for a size (0 for reserved)
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_to_bytes = 3'd1;
      SZ_HALF: size_to_bytes = 3'd2;
      SZ_WORD: size_to_bytes = 3'd4;
      default: size_to_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_extend.sv
// mem_load_extend: combinational sign/zero extension of an assembled
// N-byte load value held in the low N bytes of data_i.
//   data_i   : assembly register (low N bytes valid)
//   size_i   : request size (byte/half/word)
//   signed_i : 1 = sign-extend, 0 = zero-extend
//   data_o   : 32-bit extended result
module mem_load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & data_i[7]}}, data_i[7:0]};
      SZ_HALF: data_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer in front of a 256x8 data RAM.
// Splits byte/half/word requests into single-byte RAM beats (big-endian: the
// most significant byte goes to the lowest address), assembles and extends
// load data, and returns one response per request.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_write/size/signed/addr/wdata : request fields
//   rsp_valid/rsp_ready        : response handshake (held until taken)
//   rsp_rdata/rsp_err          : extended load data / error flag
//   ram_en/rw/addr/din/dout    : byte RAM port (ram_rw 1 = read)
// Build option: define MEM_ACCESS_MISALIGN_EN to allow misaligned half/word
// accesses (sequenced byte-by-byte with address wrap).
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  state_e              state_q;
  logic                req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]         rsp_rdata_q;
  logic                ram_en_q, ram_rw_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [7:0]          ram_din_q;

  logic                write_q, signed_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [2:0]          nbytes_q;
  logic [1:0]          beat_q;
  logic [2:0]          wait_q;
  logic [31:0]         asm_q, asm_d;
  logic [31:0]         ext_data;

  // Upper address bits are outside the RAM and intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W];

  logic [2:0] req_n;
  logic [1:0] idx_first, idx_cur, idx_nx, beat_nx;
  logic       req_err, last_beat, wait_done;

  assign req_n     = size_to_bytes(req_size);
  assign idx_first = 2'(req_n - 3'd1);
  assign beat_nx   = beat_q + 2'd1;
  // Byte lane within the N-byte value: beat 0 carries the top byte.
  assign idx_cur   = 2'(nbytes_q - 3'd1 - {1'b0, beat_q});
  assign idx_nx    = 2'(nbytes_q - 3'd1 - {1'b0, beat_nx});
  assign last_beat = ({1'b0, beat_q} == (nbytes_q - 3'd1));
  assign wait_done = (wait_q == 3'(RD_LAT - 1));

`ifdef MEM_ACCESS_MISALIGN_EN
  assign req_err = (req_size == SZ_RSVD);
`else
  assign req_err = (req_size == SZ_RSVD) ||
                   ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`endif

  // Assembly value including the byte captured this cycle, so the extended
  // result can be registered on the same edge that enters RESP.
  always_comb begin
    asm_d = asm_q;
    if (state_q == S_WAIT && wait_done)
      asm_d[{idx_cur, 3'b000} +: 8] = ram_dout;
  end

  mem_load_extend u_extend (
    .data_i   (asm_d),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= RW_READ;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= SZ_BYTE;
      addr_q      <= '0;
      wdata_q     <= '0;
      nbytes_q    <= '0;
      beat_q      <= '0;
      wait_q      <= '0;
      asm_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            write_q     <= req_write;
            signed_q    <= req_signed;
            size_q      <= req_size;
            addr_q      <= req_addr[ADDR_W-1:0];
            wdata_q     <= req_wdata;
            nbytes_q    <= req_n;
            beat_q      <= '0;
            wait_q      <= '0;
            asm_q       <= '0;
            req_ready_q <= 1'b0;
            if (req_err) begin
              // Error path goes straight to RESP without touching the RAM.
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q    <= S_ISSUE;
              ram_en_q   <= 1'b1;
              ram_rw_q   <= ~req_write;
              ram_addr_q <= req_addr[ADDR_W-1:0];
              ram_din_q  <= req_wdata[{idx_first, 3'b000} +: 8];
            end
          end
        end
        S_ISSUE: begin
          ram_en_q <= 1'b0;
          if (!write_q) begin
            state_q <= S_WAIT;
            wait_q  <= '0;
          end else if (last_beat) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end else begin
            beat_q     <= beat_nx;
            ram_en_q   <= 1'b1;
            ram_addr_q <= addr_q + ADDR_W'(beat_nx);
            ram_din_q  <= wdata_q[{idx_nx, 3'b000} +: 8];
          end
        end
        S_WAIT: begin
          if (wait_done) begin
            asm_q <= asm_d;
            if (last_beat) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= ext_data;
            end else begin
              state_q    <= S_ISSUE;
              beat_q     <= beat_nx;
              ram_en_q   <= 1'b1;
              ram_addr_q <= addr_q + ADDR_W'(beat_nx);
            end
          end else begin
            wait_q <= wait_q + 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign ram_en    = ram_en_q;
  assign ram_rw    = ram_rw_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;

endmodule
